// File: rtl/light_pkg.sv
// Shared types and constants for the RGB light sequencer.
package light_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } light_state_t;

   localparam logic [2:0] STEP_R    = 3'd0;
   localparam logic [2:0] STEP_RG   = 3'd1;
   localparam logic [2:0] STEP_G    = 3'd2;
   localparam logic [2:0] STEP_GB   = 3'd3;
   localparam logic [2:0] STEP_B    = 3'd4;
   localparam logic [2:0] STEP_RB   = 3'd5;
   localparam logic [2:0] STEP_LAST = 3'd5;

   localparam logic [3:0] LAMP_ON = 4'hF;

   // Lit-channel mask {r_on, g_on, b_on} for a step; illegal steps are dark.
   function automatic logic [2:0] step_mask(input logic [2:0] s);
      logic [2:0] m;
      case (s)
         STEP_R:  m = 3'b100;
         STEP_RG: m = 3'b110;
         STEP_G:  m = 3'b010;
         STEP_GB: m = 3'b011;
         STEP_B:  m = 3'b001;
         STEP_RB: m = 3'b101;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/light_sequencer_dwell_timer.sv
// Dwell down-counter: load takes priority, en decrements until zero.
module dwell_timer #(
   parameter int DWELL_W = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic               en,
   input  logic [DWELL_W-1:0] value,
   output logic [DWELL_W-1:0] count,
   output logic               expired
);

   assign expired = (count == '0);

   // Counter register: holds at zero rather than wrapping.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (en && !expired) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/light_sequencer.sv
// RGB lamp sequencer: R, RG, G, GB, B, RB, each held for dwell+1 clocks.
// Optional build macro LIGHT_SEQ_DIM_EN adds a 4-bit level input that
// replaces the fixed full-on lamp level.
//
// state | meaning
// OFF   | lamp dark, step 0, waiting for start
// RUN   | counting down the dwell, advancing steps on expiry
// HOLD  | paused, timer/step/colours frozen
module light_sequencer
   import light_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               pause,
   input  logic [DWELL_W-1:0] dwell,
`ifdef LIGHT_SEQ_DIM_EN
   input  logic [3:0]         level,
`endif
   output logic [3:0]         r,
   output logic [3:0]         g,
   output logic [3:0]         b,
   output logic [2:0]         step,
   output logic               running,
   output logic               wrap
);

   light_state_t       state_q, state_d;
   logic [2:0]         step_q, step_d;
   logic               wrap_d;
   logic               tmr_load, tmr_en, tmr_expired;
   logic [DWELL_W-1:0] tmr_value, tmr_count;
   logic [3:0]         on_level;
   logic [2:0]         mask_d;
   logic               lit_d;

`ifdef LIGHT_SEQ_DIM_EN
   assign on_level = level;
`else
   assign on_level = LAMP_ON;
`endif

   dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
      .clock   (clock),
      .reset   (reset),
      .load    (tmr_load),
      .en      (tmr_en),
      .value   (tmr_value),
      .count   (tmr_count),
      .expired (tmr_expired)
   );

   // State and step registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= OFF;
         step_q  <= STEP_R;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
      end
   end

   // Next-state, step advance and timer control.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      wrap_d    = 1'b0;
      tmr_load  = 1'b0;
      tmr_en    = 1'b0;
      tmr_value = dwell;
      case (state_q)
         OFF: begin
            step_d = STEP_R;
            if (start && !stop) begin
               state_d  = RUN;
               tmr_load = 1'b1;
            end else begin
               // keep the idle timer parked at zero
               tmr_load  = (tmr_count != '0);
               tmr_value = '0;
            end
         end
         RUN: begin
            if (stop) begin
               state_d   = OFF;
               step_d    = STEP_R;
               tmr_load  = 1'b1;
               tmr_value = '0;
            end else if (pause) begin
               state_d = HOLD;
            end else if (tmr_expired) begin
               tmr_load = 1'b1;
               if (step_q == STEP_LAST) begin
                  step_d = STEP_R;
                  wrap_d = 1'b1;
               end else begin
                  step_d = step_q + 3'd1;
               end
            end else begin
               tmr_en = 1'b1;
            end
         end
         HOLD: begin
            if (stop) begin
               state_d   = OFF;
               step_d    = STEP_R;
               tmr_load  = 1'b1;
               tmr_value = '0;
            end else if (!pause) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d   = OFF;
            step_d    = STEP_R;
            tmr_load  = 1'b1;
            tmr_value = '0;
         end
      endcase
      // an out-of-range step can only come from upset; fall back to idle
      if (step_q > STEP_LAST) begin
         state_d   = OFF;
         step_d    = STEP_R;
         wrap_d    = 1'b0;
         tmr_load  = 1'b1;
         tmr_en    = 1'b0;
         tmr_value = '0;
      end
   end

   assign mask_d = step_mask(step_d);
   assign lit_d  = (state_d != OFF);

   // Registered lamp drive and status outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         r       <= 4'h0;
         g       <= 4'h0;
         b       <= 4'h0;
         running <= 1'b0;
         wrap    <= 1'b0;
      end else begin
         r       <= (lit_d && mask_d[2]) ? on_level : 4'h0;
         g       <= (lit_d && mask_d[1]) ? on_level : 4'h0;
         b       <= (lit_d && mask_d[0]) ? on_level : 4'h0;
         running <= lit_d;
         wrap    <= wrap_d;
      end
   end

   assign step = step_q;

endmodule
